// File: rtl/vga_line_fetch_ctrl.sv
// vga_line_fetch_ctrl: prefetches active display lines from a double-buffered frame buffer
// as fixed-length read bursts, tracking how far ahead of the display the fetch runs.
module vga_line_fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE0 = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE1 = 32'h0010_0000,
    parameter int unsigned LINE_BYTES = 2560,
    parameter int unsigned LINE_STRIDE = 4096,
    parameter int unsigned BURST_BYTES = 256,
    parameter int unsigned V_ActivePix = 480,
    parameter int unsigned PREFETCH_LINES = 2
) (
    input  logic                  in_pclk,
    input  logic                  in_rstn,
    input  logic                  in_vs,
    input  logic                  in_de,
    input  logic                  in_frame_done,
    input  logic                  in_line_space,
    output logic                  out_rd_req,
    input  logic                  in_rd_ack,
    output logic [ADDR_WIDTH-1:0] out_rd_addr,
    output logic [15:0]           out_rd_len,
    output logic                  out_fb_sel,
    output logic                  out_underflow,
    output logic [15:0]           out_underflow_cnt
);
    localparam int unsigned BURSTS = LINE_BYTES / BURST_BYTES;

    typedef enum logic [1:0] {WAIT_VS, CHECK, REQ} state_t;
    state_t r_state, w_state_nxt;

    logic                  r_vs, r_vs_q, r_de, r_de_q;
    logic                  r_restart, r_swap_pend, r_fb_sel, r_underflow;
    logic [15:0]           r_uf_cnt;
    logic [10:0]           r_line_cnt;
    logic [7:0]            r_burst_cnt;
    logic [2:0]            r_ahead;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_line_addr;
    logic                  w_fs, w_le, w_de_rise, w_ack, w_last, w_start, w_inc, w_dec, w_issue;

    assign w_fs        = r_vs & ~r_vs_q;
    assign w_le        = ~r_de & r_de_q;
    assign w_de_rise   = r_de & ~r_de_q;
    assign w_ack       = (r_state == REQ) & in_rd_ack;
    assign w_last      = r_burst_cnt == 8'(BURSTS - 1);
    assign w_start     = (r_state == WAIT_VS) & (w_fs | r_restart);
    assign w_issue     = (r_state == CHECK) & (w_state_nxt == REQ);
    assign w_inc       = w_ack & w_last;
    assign w_dec       = w_le & (r_ahead != 3'd0);
    assign w_line_addr = (r_fb_sel ? FB_BASE1 : FB_BASE0)
                       + ADDR_WIDTH'(r_line_cnt) * ADDR_WIDTH'(LINE_STRIDE);

    assign out_rd_req        = r_state == REQ;
    assign out_rd_addr       = r_rd_addr;
    assign out_rd_len        = 16'(BURST_BYTES);
    assign out_fb_sel        = r_fb_sel;
    assign out_underflow     = r_underflow;
    assign out_underflow_cnt = r_uf_cnt;

    always_ff @(posedge in_pclk or negedge in_rstn) begin
        if (!in_rstn) r_state <= WAIT_VS;
        else          r_state <= w_state_nxt;
    end

    // A mid-frame FS detours through WAIT_VS so the restart actions happen in one place.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_VS: w_state_nxt = (w_fs | r_restart) ? CHECK : WAIT_VS;
            CHECK: begin
                if (w_fs | r_restart)                                              w_state_nxt = WAIT_VS;
                else if (r_line_cnt == 11'(V_ActivePix))                           w_state_nxt = WAIT_VS;
                else if ((r_ahead < 3'(PREFETCH_LINES)) & in_line_space)           w_state_nxt = REQ;
            end
            REQ: begin
                if (in_rd_ack & (w_fs | r_restart)) w_state_nxt = WAIT_VS;
                else if (in_rd_ack & w_last)        w_state_nxt = CHECK;
            end
            default: w_state_nxt = WAIT_VS;
        endcase
    end

    always_ff @(posedge in_pclk or negedge in_rstn) begin
        if (!in_rstn) begin
            r_vs        <= 1'b0;
            r_vs_q      <= 1'b0;
            r_de        <= 1'b0;
            r_de_q      <= 1'b0;
            r_restart   <= 1'b0;
            r_swap_pend <= 1'b0;
            r_fb_sel    <= 1'b0;
            r_underflow <= 1'b0;
            r_uf_cnt    <= 16'd0;
            r_line_cnt  <= 11'd0;
            r_burst_cnt <= 8'd0;
            r_ahead     <= 3'd0;
            r_rd_addr   <= '0;
        end else begin
            r_vs   <= in_vs;
            r_vs_q <= r_vs;
            r_de   <= in_de;
            r_de_q <= r_de;
            if (w_fs) begin
                r_fb_sel    <= r_fb_sel ^ r_swap_pend;
                r_swap_pend <= in_frame_done;
            end else if (in_frame_done) begin
                r_swap_pend <= 1'b1;
            end
            if (w_start)                           r_restart <= 1'b0;
            else if (w_fs && r_state != WAIT_VS)   r_restart <= 1'b1;
            if (w_start) begin
                r_line_cnt  <= 11'd0;
                r_burst_cnt <= 8'd0;
            end else if (w_ack) begin
                r_burst_cnt <= w_last ? 8'd0 : r_burst_cnt + 8'd1;
                r_line_cnt  <= w_last ? r_line_cnt + 11'd1 : r_line_cnt;
            end
            if (w_start)              r_ahead <= 3'd0;
            else if (w_inc && !w_dec) r_ahead <= r_ahead + 3'd1;
            else if (!w_inc && w_dec) r_ahead <= r_ahead - 3'd1;
            if (w_issue)              r_rd_addr <= w_line_addr;
            else if (w_ack && !w_last) r_rd_addr <= r_rd_addr + ADDR_WIDTH'(BURST_BYTES);
            if (w_start) r_underflow <= 1'b0;
            if (w_de_rise && r_ahead == 3'd0) begin
                r_underflow <= 1'b1;
                if (r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// tb_vga_line_fetch_ctrl: frame-level vector table plus directed sequences for the
// line fetch controller, using a small 4-line, 4-burst-per-line geometry.
module tb_vga_line_fetch_ctrl;
    logic        clk = 1'b0;
    logic        in_rstn, in_vs, in_de, in_frame_done, in_line_space, in_rd_ack;
    logic        out_rd_req, out_fb_sel, out_underflow;
    logic [31:0] out_rd_addr;
    logic [15:0] out_rd_len, out_underflow_cnt;

    always #5 clk = ~clk;

    vga_line_fetch_ctrl #(
        .ADDR_WIDTH(32), .FB_BASE0(32'h0000_0000), .FB_BASE1(32'h0010_0000),
        .LINE_BYTES(64), .LINE_STRIDE(128), .BURST_BYTES(16),
        .V_ActivePix(4), .PREFETCH_LINES(2)
    ) dut (
        .in_pclk(clk), .in_rstn(in_rstn), .in_vs(in_vs), .in_de(in_de),
        .in_frame_done(in_frame_done), .in_line_space(in_line_space),
        .out_rd_req(out_rd_req), .in_rd_ack(in_rd_ack), .out_rd_addr(out_rd_addr),
        .out_rd_len(out_rd_len), .out_fb_sel(out_fb_sel), .out_underflow(out_underflow),
        .out_underflow_cnt(out_underflow_cnt)
    );

    typedef struct {
        int          delay;
        bit          done;
        bit          late;
        bit          lat;
        logic [31:0] first;
        bit          fb;
        bit          uf;
        logic [15:0] ufc;
    } row_t;

    row_t        rows[6];
    logic [31:0] q[$];
    logic [31:0] last_addr = 32'd0;
    int n_vec = 0, n_err = 0, cur_row = -1;
    int ack_delay = 0, ack_limit = 1 << 30;
    int hold = 0, hmin = 9999, hmax = 0, stab_err = 0, req_seen = 0, nle = 0, seq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %0h expected %0h", cur_row, nm, act, exp);
        end
    endtask

    // Acknowledge responder and request monitor share one block so the ack decision
    // and the address capture see the same sample.
    always @(negedge clk) begin
        if (out_rd_req) begin
            req_seen++;
            if (hold > 0 && out_rd_addr != last_addr) stab_err++;
            last_addr = out_rd_addr;
            hold++;
            if (hold > ack_delay && q.size() < ack_limit) begin
                in_rd_ack = 1'b1;
                q.push_back(out_rd_addr);
                if (hold < hmin) hmin = hold;
                if (hold > hmax) hmax = hold;
                hold = 0;
            end else begin
                in_rd_ack = 1'b0;
            end
        end else begin
            in_rd_ack = 1'b0;
            hold = 0;
        end
    end

    task automatic frame(input bit done, input bit late, input bit lat);
        in_vs = 1'b0;
        in_line_space = !late;
        repeat (4) @(negedge clk);
        q.delete();
        hmin = 9999;
        hmax = 0;
        stab_err = 0;
        in_vs = 1'b1;
        repeat (2) @(negedge clk);
        if (lat) chk("lat_cycle2", 32'(out_rd_req), 32'd0);
        @(negedge clk);
        if (lat) chk("lat_cycle3", 32'(out_rd_req), 32'd1);
        repeat (37) @(negedge clk);
        for (int l = 0; l < 4; l++) begin
            in_de = 1'b1;
            for (int c = 0; c < 16; c++) begin
                in_frame_done = done && l == 1 && c == 0;
                if (late && c == 2) in_line_space = 1'b1;
                @(negedge clk);
            end
            in_frame_done = 1'b0;
            if (l == 0) nle = q.size();
            in_de = 1'b0;
            repeat (40) @(negedge clk);
        end
    endtask

    initial begin
        rows[0] = '{0, 0, 0, 1, 32'h0000_0000, 0, 0, 16'd0};
        rows[1] = '{5, 1, 0, 0, 32'h0000_0000, 0, 0, 16'd0};
        rows[2] = '{0, 0, 0, 0, 32'h0010_0000, 1, 0, 16'd0};
        rows[3] = '{0, 0, 0, 0, 32'h0010_0000, 1, 0, 16'd0};
        rows[4] = '{0, 0, 1, 0, 32'h0010_0000, 1, 1, 16'd1};
        rows[5] = '{0, 0, 0, 0, 32'h0010_0000, 1, 0, 16'd1};
        in_rstn = 1'b0;
        in_vs = 1'b0;
        in_de = 1'b0;
        in_frame_done = 1'b0;
        in_line_space = 1'b1;
        in_rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(out_rd_req), 32'd0);
        chk("rst_addr", out_rd_addr, 32'd0);
        chk("rst_fb", 32'(out_fb_sel), 32'd0);
        chk("rst_uf", 32'(out_underflow), 32'd0);
        chk("rst_ufcnt", 32'(out_underflow_cnt), 32'd0);
        chk("rd_len", 32'(out_rd_len), 32'd16);
        in_rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("static_vs_noreq", req_seen, 32'd0);

        for (int r = 0; r < 6; r++) begin
            cur_row = r;
            ack_delay = rows[r].delay;
            frame(rows[r].done, rows[r].late, rows[r].lat);
            chk("count", q.size(), 32'd16);
            chk("first", q[0], rows[r].first);
            chk("last", q[15], rows[r].first + 32'h1B0);
            seq = 0;
            foreach (q[i]) if (q[i] != rows[r].first + 32'((i / 4) * 128 + (i % 4) * 16)) seq++;
            chk("seq_err", seq, 32'd0);
            chk("pre_le", nle, 32'd8);
            chk("hold_min", hmin, 32'(rows[r].delay + 1));
            chk("hold_max", hmax, 32'(rows[r].delay + 1));
            chk("stable", stab_err, 32'd0);
            chk("fb_sel", 32'(out_fb_sel), 32'(rows[r].fb));
            chk("underflow", 32'(out_underflow), 32'(rows[r].uf));
            chk("uf_cnt", 32'(out_underflow_cnt), 32'(rows[r].ufc));
        end

        // FS while a request waits for its ack: request holds, then fetch restarts at line 0.
        cur_row = 6;
        ack_delay = 0;
        ack_limit = 2;
        in_vs = 1'b0;
        repeat (4) @(negedge clk);
        q.delete();
        stab_err = 0;
        in_vs = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_cnt", q.size(), 32'd2);
        chk("held_req", 32'(out_rd_req), 32'd1);
        chk("held_addr", out_rd_addr, 32'h0010_0020);
        in_vs = 1'b0;
        repeat (3) @(negedge clk);
        in_vs = 1'b1;
        repeat (8) @(negedge clk);
        chk("fs_held_req", 32'(out_rd_req), 32'd1);
        chk("fs_held_addr", out_rd_addr, 32'h0010_0020);
        ack_limit = 1 << 30;
        repeat (20) @(negedge clk);
        chk("restart_q2", q[2], 32'h0010_0020);
        chk("restart_q3", q[3], 32'h0010_0000);
        chk("restart_q4", q[4], 32'h0010_0010);
        chk("restart_stable", stab_err, 32'd0);
        chk("restart_fb", 32'(out_fb_sel), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
